// File: rtl/rx_udp_demux.sv
// UDP payload demux: steers each datagram into the first enabled channel whose port matches; one byte per cycle, irq one cycle after end.
// No backpressure toward the UDP layer; full FIFO sets ovf. Macro RX_UDP_DEMUX_ATOMIC_EN: datagrams become visible only when complete.
module rx_udp_demux #(
  parameter int CH_NUM     = 4,
  parameter int DEPTH_LOG2 = 9,
  parameter int OCT        = 8
) (
  input  logic                             RX_CLK,
  input  logic                             rst,
  input  logic [CH_NUM*16-1:0]             port_cfg,
  input  logic [CH_NUM-1:0]                ch_en,
  input  logic [15:0]                      rx_dst_port,
  input  logic                             rx_sof,
  input  logic                             rx_data_v,
  input  logic [OCT-1:0]                   rx_data,
  input  logic [CH_NUM-1:0]                rd_en,
  output logic [CH_NUM*OCT-1:0]            rd_data,
  output logic [CH_NUM-1:0]                rd_empty,
  output logic [CH_NUM*(DEPTH_LOG2+1)-1:0] rd_count,
  output logic [CH_NUM-1:0]                ch_irq,
  output logic [CH_NUM-1:0]                ovf,
  input  logic [CH_NUM-1:0]                ovf_clr
);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int CW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t                     state, state_nxt;
  logic                       prev_v;
  logic [CW-1:0]              cur_ch;
  logic [PW-1:0]              cur_ptr, fs_ptr;
  logic                       trunc;
  logic [CH_NUM-1:0][PW-1:0]  wr_ptr, rd_ptr;
  logic [OCT-1:0]             mem [CH_NUM][DEPTH];

  logic                       match_vld;
  logic [CW-1:0]              match_idx;
  logic [CH_NUM-1:0]          do_rd, ovf_set, irq_nxt;
  logic [PW-1:0]              rd_cur;
  logic                       full, accept, wr_ok, ovf_hit, edge_end, start, dg_end;

  genvar g;
  generate
    for (g = 0; g < CH_NUM; g++) begin : g_rd
      assign rd_count[g*PW +: PW] = wr_ptr[g] - rd_ptr[g];
      assign rd_empty[g]          = (wr_ptr[g] == rd_ptr[g]);
      assign do_rd[g]             = rd_en[g] & ~rd_empty[g];
    end
  endgenerate

  // Lowest-index enabled slot wins, so scan from the top down.
  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_en[i] && (port_cfg[16*i +: 16] == rx_dst_port)) begin
        match_vld = 1'b1;
        match_idx = CW'(i);
      end
    end
  end

  // cur_ptr is the in-flight write pointer; a same-cycle read frees a slot.
  assign rd_cur   = rd_ptr[cur_ch];
  assign full     = (cur_ptr[PW-1] != rd_cur[PW-1]) && (cur_ptr[PW-2:0] == rd_cur[PW-2:0]);
  assign accept   = (state == RECV) && rx_data_v && !rx_sof;
  assign wr_ok    = accept && (!full || do_rd[cur_ch]);
  assign ovf_hit  = accept && !wr_ok;
  assign edge_end = prev_v && !rx_data_v;

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      ovf_set[i] = ovf_hit && (cur_ch == CW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = '0;
    start     = 1'b0;
    dg_end    = 1'b0;
    if (rx_sof) begin
      start     = match_vld;
      state_nxt = match_vld ? RECV : DISCARD;
    end else begin
      case (state)
        RECV: begin
          if (ovf_hit) begin
            state_nxt = DISCARD;
          end else if (edge_end) begin
            state_nxt = IDLE;
            dg_end    = 1'b1;
            if (cur_ptr != fs_ptr) irq_nxt[cur_ch] = 1'b1;
          end
        end
        DISCARD: begin
          if (edge_end) begin
            state_nxt = IDLE;
            if (trunc) irq_nxt[cur_ch] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prev_v  <= 1'b0;
      cur_ch  <= '0;
      cur_ptr <= '0;
      fs_ptr  <= '0;
      trunc   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ch_irq  <= '0;
      ovf     <= '0;
      rd_data <= '0;
    end else begin
      state  <= state_nxt;
      prev_v <= rx_data_v;
      ch_irq <= irq_nxt;
      ovf    <= (ovf & ~ovf_clr) | ovf_set;
      if (start) begin
        cur_ch  <= match_idx;
        cur_ptr <= wr_ptr[match_idx];
        fs_ptr  <= wr_ptr[match_idx];
      end else if (wr_ok) begin
        cur_ptr <= cur_ptr + PW'(1);
      end
`ifdef RX_UDP_DEMUX_ATOMIC_EN
      // Uncommitted bytes are dropped simply by never publishing cur_ptr.
      if (dg_end) wr_ptr[cur_ch] <= cur_ptr;
      if (rx_sof) trunc <= 1'b0;
`else
      if (wr_ok) wr_ptr[cur_ch] <= cur_ptr + PW'(1);
      // A truncated datagram still signals completion if part of it was kept.
      if (rx_sof) trunc <= 1'b0;
      else if (ovf_hit && (cur_ptr != fs_ptr)) trunc <= 1'b1;
`endif
      for (int i = 0; i < CH_NUM; i++) begin
        if (do_rd[i]) begin
          rd_ptr[i]            <= rd_ptr[i] + PW'(1);
          rd_data[i*OCT +: OCT] <= mem[i][rd_ptr[i][DEPTH_LOG2-1:0]];
        end
      end
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (wr_ok) mem[cur_ch][cur_ptr[DEPTH_LOG2-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_rx_udp_demux.sv
// Bench for rx_udp_demux (4 channels, 16-byte FIFOs); expectations follow RX_UDP_DEMUX_ATOMIC_EN when defined.
module tb_rx_udp_demux;
  localparam int CH = 4, DL = 4, OCT = 8, PW = DL + 1, DEPTH = 16;

  logic              RX_CLK = 1'b0;
  logic              rst;
  logic [CH*16-1:0]  port_cfg;
  logic [CH-1:0]     ch_en, rd_en, ovf_clr, rd_empty, ch_irq, ovf;
  logic [15:0]       rx_dst_port;
  logic              rx_sof, rx_data_v;
  logic [OCT-1:0]    rx_data;
  logic [CH*OCT-1:0] rd_data;
  logic [CH*PW-1:0]  rd_count;

  rx_udp_demux #(.CH_NUM(CH), .DEPTH_LOG2(DL), .OCT(OCT)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .port_cfg(port_cfg), .ch_en(ch_en),
    .rx_dst_port(rx_dst_port), .rx_sof(rx_sof), .rx_data_v(rx_data_v), .rx_data(rx_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_count(rd_count),
    .ch_irq(ch_irq), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 RX_CLK = ~RX_CLK;

  typedef struct {
    logic [15:0] port;
    int          n;
    logic [7:0]  base;
    int          ch;
  } vec_t;

  int         tests = 0, fails = 0;
  int         irq_cnt [CH];
  logic [7:0] sbq [CH][$];
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge RX_CLK);
    #1;
  endtask

  always @(negedge RX_CLK) begin
    for (int i = 0; i < CH; i++) if (ch_irq[i]) irq_cnt[i]++;
  end

  // Streaming reader for channel 0 used while reads overlap writes.
  always begin : rmon
    bit         t;
    logic [7:0] e;
    @(negedge RX_CLK);
    t = mon_en && rd_en[0] && !rd_empty[0];
    @(posedge RX_CLK);
    #1;
    if (t) begin
      if (sbq[0].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wrap_extra: got 0x%0h, expected no byte", rd_data[7:0]);
      end else begin
        e = sbq[0].pop_front();
        chk("wrap_data", {24'h0, rd_data[7:0]}, {24'h0, e});
      end
    end
  end

  // Drives one datagram; the expected stored bytes are pushed to the scoreboard.
  task automatic send(input logic [15:0] port, input int n, input logic [7:0] base, input int ch,
                      input bit cap, output int exp_irq, output bit exp_ovf);
    int keep;
    keep    = (ch >= 0) ? n : 0;
    exp_ovf = 1'b0;
    if (ch >= 0 && cap && n > DEPTH - sbq[ch].size()) begin
      exp_ovf = 1'b1;
`ifdef RX_UDP_DEMUX_ATOMIC_EN
      keep = 0;
`else
      keep = DEPTH - sbq[ch].size();
`endif
    end
    for (int k = 0; k < keep; k++) sbq[ch].push_back(base + 8'(k));
    exp_irq = (keep > 0) ? 1 : 0;
    rx_dst_port = port;
    rx_sof = 1'b1;
    tick();
    rx_sof = 1'b0;
    for (int k = 0; k < n; k++) begin
      rx_data_v = 1'b1;
      rx_data   = base + 8'(k);
      tick();
    end
    rx_data_v = 1'b0;
    tick();
  endtask

  task automatic drain(input int c, input string nm);
    logic [7:0] e, last;
    int         got;
    last = 8'h0;
    got  = 0;
    while (sbq[c].size() > 0) begin
      e = sbq[c].pop_front();
      rd_en[c] = 1'b1;
      tick();
      rd_en[c] = 1'b0;
      chk({nm, "_data"}, {24'h0, rd_data[c*OCT +: OCT]}, {24'h0, e});
      last = e;
      got++;
    end
    chk({nm, "_empty"}, {31'h0, rd_empty[c]}, 32'h1);
    rd_en[c] = 1'b1;
    tick();
    rd_en[c] = 1'b0;
    if (got > 0) chk({nm, "_hold"}, {24'h0, rd_data[c*OCT +: OCT]}, {24'h0, last});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [4];
    int   ei, ib [CH];
    bit   eo;

    rst = 1'b0; port_cfg = '0; ch_en = '0; rx_dst_port = '0; rx_sof = 1'b0;
    rx_data_v = 1'b0; rx_data = '0; rd_en = '0; ovf_clr = '0;
    for (int i = 0; i < CH; i++) irq_cnt[i] = 0;

    #12;
    chk("rst_empty", {28'h0, rd_empty}, 32'hf);
    chk("rst_count", {12'h0, rd_count}, 32'h0);
    chk("rst_data", rd_data, 32'h0);
    chk("rst_irq", {28'h0, ch_irq}, 32'h0);
    chk("rst_ovf", {28'h0, ovf}, 32'h0);
    @(negedge RX_CLK);
    rst = 1'b1;
    tick(); tick();

    port_cfg = {16'h0777, 16'h0050, 16'h0050, 16'h1234};
    ch_en    = 4'b0111;
    vecs[0] = '{16'h1234, 5, 8'h01, 0};
    vecs[1] = '{16'h0050, 3, 8'h10, 1};
    vecs[2] = '{16'h0051, 4, 8'h20, -1};
    vecs[3] = '{16'h0777, 2, 8'h30, -1};
    for (int v = 0; v < 4; v++) begin
      ib = irq_cnt;
      send(vecs[v].port, vecs[v].n, vecs[v].base, vecs[v].ch, 1'b1, ei, eo);
      tick(); tick(); tick();
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("vec%0d_irq%0d", v, i), irq_cnt[i] - ib[i], (i == vecs[v].ch) ? ei : 0);
        chk($sformatf("vec%0d_cnt%0d", v, i), {27'h0, rd_count[i*PW +: PW]}, sbq[i].size());
      end
    end
    chk("mr_count5", {27'h0, rd_count[4:0]}, 32'd5);
    drain(0, "mr");
    drain(1, "pri");

    ib = irq_cnt;
    send(16'h1234, 20, 8'h40, 0, 1'b1, ei, eo);
    tick(); tick(); tick();
    chk("ovf_irq", irq_cnt[0] - ib[0], ei);
    chk("ovf_count", {27'h0, rd_count[4:0]}, sbq[0].size());
    chk("ovf_flag", {31'h0, ovf[0]}, {31'h0, eo});
    ovf_clr[0] = 1'b1;
    tick();
    ovf_clr[0] = 1'b0;
    chk("ovf_clr", {31'h0, ovf[0]}, 32'h0);
    drain(0, "ovf");
    ib = irq_cnt;
    send(16'h1234, 4, 8'h58, 0, 1'b1, ei, eo);
    tick(); tick(); tick();
    chk("after_ovf_irq", irq_cnt[0] - ib[0], 32'd1);
    chk("after_ovf_count", {27'h0, rd_count[4:0]}, 32'd4);
    drain(0, "after_ovf");

    ib = irq_cnt;
    mon_en = 1'b1;
    rd_en[0] = 1'b1;
    send(16'h1234, 14, 8'h80, 0, 1'b0, ei, eo);
    tick();
    send(16'h1234, 13, 8'h8e, 0, 1'b0, ei, eo);
    tick();
    send(16'h1234, 13, 8'h9b, 0, 1'b0, ei, eo);
    for (int w = 0; w < 100 && sbq[0].size() > 0; w++) tick();
    if (sbq[0].size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wrap_drain: %0d bytes still expected, required 0", sbq[0].size());
    end
    rd_en[0] = 1'b0;
    tick();
    mon_en = 1'b0;
    chk("wrap_ovf", {28'h0, ovf}, 32'h0);
    chk("wrap_empty", {31'h0, rd_empty[0]}, 32'h1);
    chk("wrap_irq", irq_cnt[0] - ib[0], 32'd3);

    rx_dst_port = 16'h1234;
    rx_sof = 1'b1;
    tick();
    rx_sof = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_data_v = 1'b1;
      rx_data   = 8'h60 + 8'(k);
      tick();
    end
    #3;
    rst = 1'b0;
    #1;
    chk("arst_empty", {28'h0, rd_empty}, 32'hf);
    chk("arst_count", {12'h0, rd_count}, 32'h0);
    chk("arst_data", rd_data, 32'h0);
    chk("arst_irq", {28'h0, ch_irq}, 32'h0);
    rx_data_v = 1'b0;
    @(negedge RX_CLK);
    rst = 1'b1;
    tick(); tick();
    ib = irq_cnt;
    send(16'h1234, 4, 8'h70, 0, 1'b1, ei, eo);
    tick(); tick(); tick();
    chk("post_irq", irq_cnt[0] - ib[0], 32'd1);
    chk("post_count", {27'h0, rd_count[4:0]}, 32'd4);
    drain(0, "post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
